frase_controller: RTL and testbench
===================================

Name: frase_controller

Overview:
- Sequencer that feeds the note-to-word-class classifier (substantivo) one note at a time.
- Collects the returned 2-bit word types into a sentence buffer and detects the end-of-sentence note.
- Checks a minimal grammar rule and reports the finished sentence, or an error, to the top level.
- Sits between the note input (switches/keypad decoder) and the display/result logic.

Parameters:
- MAX_WORDS, 8: sentence buffer depth in words.
- CLS_LAT, 2: classifier latency in cycles, from Cls_Ready assertion to a valid Cls_Tipo/Cls_End.
- CW, 4: Word_Count width; must satisfy 2^CW > MAX_WORDS.

Ports:
- clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous reset, active-low (Reset==0 resets on the clk edge).
- Note_Valid  input  1  a note is presented on Tom_in/Nota_in.
- Note_Ready  output  1  controller can accept a note.
- Tom_in  input  1  note tone.
- Nota_in  input  3  note code.
- Cls_Ready  output  1  enable to the classifier.
- Cls_Tom  output  1  tone driven to the classifier.
- Cls_Nota  output  3  note driven to the classifier.
- Cls_Tipo  input  2  classifier word type: 11, 10, 01, or 00 (unrecognised).
- Cls_End  input  1  classifier flagged end-of-sentence.
- Sentence  output  2*MAX_WORDS  packed word types; word i is at bits [2i+1:2i].
- Word_Count  output  CW  number of stored words.
- Busy  output  1  a note is in flight to the classifier.
- Done  output  1  sentence complete and valid.
- Error  output  1  sentence aborted or rejected.
- Error_Code  output  2  00 none, 01 invalid note, 10 overflow, 11 grammar.
- Ack  input  1  consumer acknowledges Done/Error.

Behaviour:
- Reset (Reset==0 at a clk edge):
  - State becomes IDLE.
  - Sentence, Word_Count, Cls_Tom, Cls_Nota, Cls_Ready, Busy, Done, Error and Error_Code all become 0.
  - Reset mid-operation (any state) aborts the sentence the same way; the in-flight note is discarded.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Note_Ready=1.
  - On a clk edge with Note_Valid=1: latch Tom_in→Cls_Tom and Nota_in→Cls_Nota, then go to ISSUE.
  - Note_Valid=0: stay in IDLE.
- ISSUE:
  - Cls_Ready=1, Busy=1, Note_Ready=0.
  - Load latency counter with CLS_LAT-1, then go to WAIT.
- WAIT:
  - Cls_Ready, Busy and Cls_Tom/Cls_Nota are held stable; counter decrements each cycle.
  - When the counter is 0, sample Cls_End/Cls_Tipo on that edge and decide with the first matching rule:
    1. Cls_End=1 and (Word_Count==0 or Sentence[1:0]!=2'b11): Error=1, Error_Code=11.
    2. Cls_End=1 otherwise: Done=1.
    3. Cls_Tipo==00: Error=1, Error_Code=01.
    4. Word_Count==MAX_WORDS: Error=1, Error_Code=10; the buffer is not modified.
    5. Otherwise: store Cls_Tipo at slot Word_Count, increment Word_Count, return to IDLE.
  - Rules 1–4 go to DONE.
  - Cls_Ready and Busy deassert on the same edge.
- DONE:
  - Note_Ready=0; Note_Valid is ignored.
  - Done/Error, Error_Code, Sentence and Word_Count are held.
  - Ack=1 at an edge: clear Sentence, Word_Count, Done, Error and Error_Code, then go to IDLE.
  - Ack outside DONE has no effect.
- Timing:
  - Per-note throughput: 1 + 1 + CLS_LAT cycles (accept, ISSUE, WAIT).
  - Done/Error are asserted CLS_LAT+1 edges after the accept edge of the end note.
- Invariants:
  - Done and Error are never both 1.
  - Word_Count never exceeds MAX_WORDS.
  - Unused Sentence slots are 0.
  - Cls_Ready=1 only in ISSUE/WAIT.

Test Plan:
- Reset: hold Reset=0 for 2 cycles with Note_Valid=1 → all outputs 0, Note_Ready=1. Release → next note accepted normally.
- Valid sentence (default params):
  - Stimulus: notes (0,011), (0,100), (0,101), (0,000), each presented when Note_Ready=1.
  - Expect Done=1, Error=0, Word_Count=3, Sentence[5:0]=01_10_11, upper bits 0.
  - Ack → Word_Count=0, Done=0, Note_Ready=1 on the next cycle.
- Invalid note: (0,111) first → Error=1, Error_Code=01, Word_Count=0. Done stays 0 until Ack.
- Overflow: nine notes (0,011) → after the 9th, Error_Code=10, Word_Count=8, Sentence=16'hFFFF.
- Grammar:
  - (0,100) then (0,000) → Error_Code=11, Word_Count=1.
  - (1,000) alone → Error_Code=11, Word_Count=0.
- Mid-operation and handshake checks:
  - Assert Reset=0 during WAIT of the 2nd note → next cycle Word_Count=0, Cls_Ready=0, state IDLE.
  - Pulse Note_Valid during DONE → no change to any output.

Source files
------------

// File: rtl/frase_controller.sv
// Sentence sequencer: issues one note at a time to the word classifier, buffers
// the returned word types and reports a finished sentence or an error code.
module frase_controller #(
  parameter int MAX_WORDS = 8,
  parameter int CLS_LAT   = 2,
  parameter int CW        = 4
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic                   Note_Valid,
  output logic                   Note_Ready,
  input  logic                   Tom_in,
  input  logic [2:0]             Nota_in,
  output logic                   Cls_Ready,
  output logic                   Cls_Tom,
  output logic [2:0]             Cls_Nota,
  input  logic [1:0]             Cls_Tipo,
  input  logic                   Cls_End,
  output logic [2*MAX_WORDS-1:0] Sentence,
  output logic [CW-1:0]          Word_Count,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Error,
  output logic [1:0]             Error_Code,
  input  logic                   Ack
);

  localparam int LW = (CLS_LAT > 1) ? $clog2(CLS_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                 r_state;
  logic [LW-1:0]          r_lat;
  logic                   r_note_ready;
  logic                   r_cls_ready;
  logic                   r_cls_tom;
  logic [2:0]             r_cls_nota;
  logic [2*MAX_WORDS-1:0] r_sentence;
  logic [CW-1:0]          r_word_count;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;
  logic [1:0]             r_error_code;

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_state      <= S_IDLE;
      r_lat        <= '0;
      r_note_ready <= 1'b1;
      r_cls_ready  <= 1'b0;
      r_cls_tom    <= 1'b0;
      r_cls_nota   <= 3'b000;
      r_sentence   <= '0;
      r_word_count <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_error_code <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Note_Valid) begin
            r_cls_tom    <= Tom_in;
            r_cls_nota   <= Nota_in;
            r_cls_ready  <= 1'b1;
            r_busy       <= 1'b1;
            r_note_ready <= 1'b0;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_lat   <= LW'(CLS_LAT - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_lat != '0) begin
            r_lat <= r_lat - LW'(1);
          end else begin
            // Classifier result is valid on this edge only.
            r_cls_ready <= 1'b0;
            r_busy      <= 1'b0;
            if (Cls_End && (r_word_count == '0 || r_sentence[1:0] != 2'b11)) begin
              r_error      <= 1'b1;
              r_error_code <= 2'b11;
              r_state      <= S_DONE;
            end else if (Cls_End) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (Cls_Tipo == 2'b00) begin
              r_error      <= 1'b1;
              r_error_code <= 2'b01;
              r_state      <= S_DONE;
            end else if (r_word_count == CW'(MAX_WORDS)) begin
              r_error      <= 1'b1;
              r_error_code <= 2'b10;
              r_state      <= S_DONE;
            end else begin
              for (int i = 0; i < MAX_WORDS; i++) begin
                if (r_word_count == CW'(i)) r_sentence[2*i +: 2] <= Cls_Tipo;
              end
              r_word_count <= r_word_count + CW'(1);
              r_note_ready <= 1'b1;
              r_state      <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          if (Ack) begin
            r_sentence   <= '0;
            r_word_count <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_error_code <= 2'b00;
            r_note_ready <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Note_Ready = r_note_ready;
  assign Cls_Ready  = r_cls_ready;
  assign Cls_Tom    = r_cls_tom;
  assign Cls_Nota   = r_cls_nota;
  assign Sentence   = r_sentence;
  assign Word_Count = r_word_count;
  assign Busy       = r_busy;
  assign Done       = r_done;
  assign Error      = r_error;
  assign Error_Code = r_error_code;

endmodule

// File: tb/tb_frase_controller.sv
// Scoreboard bench for frase_controller: a latency-accurate classifier stub,
// a sentence-level reference model, and a monitor that checks each result.
module tb_frase_controller;

  localparam int MAXW = 8;
  localparam int LAT  = 2;
  localparam int CWW  = 4;
  localparam int SW   = 2 * MAXW;

  logic           clk = 1'b0;
  logic           Reset = 1'b0;
  logic           Note_Valid = 1'b0;
  logic           Note_Ready;
  logic           Tom_in = 1'b0;
  logic [2:0]     Nota_in = 3'b000;
  logic           Cls_Ready;
  logic           Cls_Tom;
  logic [2:0]     Cls_Nota;
  logic [1:0]     Cls_Tipo;
  logic           Cls_End;
  logic [SW-1:0]  Sentence;
  logic [CWW-1:0] Word_Count;
  logic           Busy;
  logic           Done;
  logic           Error;
  logic [1:0]     Error_Code;
  logic           Ack = 1'b0;

  frase_controller #(.MAX_WORDS(MAXW), .CLS_LAT(LAT), .CW(CWW)) dut (
    .clk(clk), .Reset(Reset), .Note_Valid(Note_Valid), .Note_Ready(Note_Ready),
    .Tom_in(Tom_in), .Nota_in(Nota_in), .Cls_Ready(Cls_Ready), .Cls_Tom(Cls_Tom),
    .Cls_Nota(Cls_Nota), .Cls_Tipo(Cls_Tipo), .Cls_End(Cls_End), .Sentence(Sentence),
    .Word_Count(Word_Count), .Busy(Busy), .Done(Done), .Error(Error),
    .Error_Code(Error_Code), .Ack(Ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Classifier stub: word type depends on the note code; tone is ignored.
  function automatic logic [1:0] tipo_of(input logic [2:0] n);
    case (n)
      3'd1, 3'd3: tipo_of = 2'b11;
      3'd4, 3'd6: tipo_of = 2'b10;
      3'd2, 3'd5: tipo_of = 2'b01;
      default:    tipo_of = 2'b00;
    endcase
  endfunction

  // Result only becomes valid LAT cycles after Cls_Ready rises.
  logic [3:0] lat_cnt = 4'd0;
  always @(posedge clk) begin
    if (!Cls_Ready) lat_cnt <= 4'd0;
    else if (lat_cnt != 4'd15) lat_cnt <= lat_cnt + 4'd1;
  end
  wire w_cls_valid = Cls_Ready && (lat_cnt == 4'(LAT));
  assign Cls_Tipo = w_cls_valid ? tipo_of(Cls_Nota) : 2'b00;
  assign Cls_End  = w_cls_valid && (Cls_Nota == 3'b000);

  typedef struct {
    logic          done;
    logic          err;
    logic [1:0]    code;
    int            count;
    logic [SW-1:0] sent;
    int            consumed;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] stim_q[$];

  // Sentence-level reference: walk notes until one terminates the sentence.
  function automatic exp_t model();
    exp_t       e;
    logic [1:0] w[MAXW];
    int         cnt = 0;
    e.done = 0; e.err = 0; e.code = 2'b00; e.sent = '0; e.consumed = stim_q.size();
    foreach (w[k]) w[k] = 2'b00;
    for (int i = 0; i < stim_q.size(); i++) begin
      logic [2:0] n = stim_q[i][2:0];
      if (n == 3'b000) begin
        if (cnt == 0 || w[0] != 2'b11) begin e.err = 1; e.code = 2'b11; end
        else e.done = 1;
        e.consumed = i + 1; break;
      end
      if (tipo_of(n) == 2'b00) begin e.err = 1; e.code = 2'b01; e.consumed = i + 1; break; end
      if (cnt == MAXW) begin e.err = 1; e.code = 2'b10; e.consumed = i + 1; break; end
      w[cnt] = tipo_of(n);
      cnt++;
    end
    e.count = cnt;
    for (int k = 0; k < cnt; k++) e.sent[2*k +: 2] = w[k];
    return e;
  endfunction

  // Monitor: pops the scoreboard when a result first appears.
  initial begin
    logic seen = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (Reset && (Done || Error) && !seen) begin
        seen = 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(Done | Error), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done", 32'(Done), 32'(e.done));
          chk("error", 32'(Error), 32'(e.err));
          chk("error_code", 32'(Error_Code), 32'(e.code));
          chk("word_count", 32'(Word_Count), 32'(e.count));
          chk("sentence", 32'(Sentence), 32'(e.sent));
          chk("result_latency", 32'(cyc - last_acc), 32'(LAT + 1));
        end
      end
      if (!Done && !Error) seen = 0;
      if (Reset) begin
        chk("done_and_error", 32'(Done && Error), 32'd0);
        chk("count_bound", 32'(Word_Count > 4'(MAXW)), 32'd0);
        chk("ready_excl", 32'(Cls_Ready && Note_Ready), 32'd0);
      end
    end
  end

  task automatic send_note(input logic [3:0] nt);
    int k = 0;
    do begin @(negedge clk); k++; end while (!Note_Ready && k < 20);
    if (!Note_Ready) chk("note_ready_timeout", 32'(Note_Ready), 32'd1);
    Note_Valid = 1'b1; Tom_in = nt[3]; Nota_in = nt[2:0];
    @(posedge clk); #1;
    last_acc = cyc;
    Note_Valid = 1'b0;
  endtask

  task automatic run_sentence();
    exp_t e = model();
    int   k = 0;
    exp_q.push_back(e);
    for (int i = 0; i < e.consumed; i++) send_note(stim_q[i]);
    do begin @(negedge clk); k++; end while (!(Done || Error) && k < 20);
    if (!(Done || Error)) begin
      chk("result_timeout", 32'(Done | Error), 32'd1);
      void'(exp_q.pop_front());
      return;
    end
    Note_Valid = 1'b1; Tom_in = 1'b0; Nota_in = 3'($urandom_range(7, 1));
    @(negedge clk);
    @(negedge clk);
    Note_Valid = 1'b0;
    chk("hold_done", 32'(Done), 32'(e.done));
    chk("hold_error", 32'(Error), 32'(e.err));
    chk("hold_code", 32'(Error_Code), 32'(e.code));
    chk("hold_count", 32'(Word_Count), 32'(e.count));
    chk("hold_sentence", 32'(Sentence), 32'(e.sent));
    chk("hold_note_ready", 32'(Note_Ready), 32'd0);
    Ack = 1'b1;
    @(negedge clk);
    Ack = 1'b0;
    chk("ack_clear", {Done, Error, Error_Code, Word_Count, Sentence}, 32'd0);
    chk("ack_note_ready", 32'(Note_Ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; Note_Valid = 1'b1; Nota_in = 3'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {Cls_Ready, Busy, Done, Error, Error_Code, Word_Count, Cls_Tom, Cls_Nota},
        32'd0);
    chk("rst_sentence", 32'(Sentence), 32'd0);
    chk("rst_note_ready", 32'(Note_Ready), 32'd1);
    Note_Valid = 1'b0; Reset = 1'b1;

    stim_q = '{4'h3, 4'h4, 4'h5, 4'h0};
    run_sentence();
    stim_q = '{4'h7};
    run_sentence();
    stim_q = '{4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3};
    run_sentence();
    stim_q = '{4'h4, 4'h0};
    run_sentence();
    stim_q = '{4'h8};
    run_sentence();

    send_note(4'h3);
    begin
      int k = 0;
      do begin @(negedge clk); k++; end while (!Note_Ready && k < 20);
    end
    chk("mid_count_before", 32'(Word_Count), 32'd1);
    chk("mid_sentence_before", 32'(Sentence), 32'h3);
    send_note(4'h4);
    @(posedge clk); #1;
    Reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_count", 32'(Word_Count), 32'd0);
    chk("mid_rst_cls_ready", 32'(Cls_Ready), 32'd0);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_note_ready", 32'(Note_Ready), 32'd1);
    chk("mid_rst_sentence", 32'(Sentence), 32'd0);
    Reset = 1'b1;

    for (int s = 0; s < 40; s++) begin
      int n = $urandom_range(9, 0);
      stim_q.delete();
      if (n > 0) stim_q.push_back(($urandom_range(1, 0) == 1) ? 4'h3 : 4'($urandom_range(15, 1)));
      for (int i = 1; i < n; i++) begin
        logic [2:0] nn = ($urandom_range(11, 0) == 0) ? 3'd7 : 3'($urandom_range(6, 1));
        stim_q.push_back({1'($urandom_range(1, 0)), nn});
      end
      stim_q.push_back({1'($urandom_range(1, 0)), 3'b000});
      run_sentence();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
